// File: rtl/ps2_pkg.sv
// Shared PS/2 decode definitions: FSM states, prefix bytes, dropped control
// bytes, the eight tracked game keys and the 10-bit event word.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Game key scan codes (set 2, non-extended) and their key_held bit positions
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_B     = 8'h32;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  localparam int KEY_W_BIT     = 0;
  localparam int KEY_A_BIT     = 1;
  localparam int KEY_S_BIT     = 2;
  localparam int KEY_D_BIT     = 3;
  localparam int KEY_R_BIT     = 4;
  localparam int KEY_G_BIT     = 5;
  localparam int KEY_B_BIT     = 6;
  localparam int KEY_SPACE_BIT = 7;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // Controller/self-test responses that carry no key information.
  function automatic logic is_dropped_byte(input logic [7:0] b);
    case (b)
      PFX_E1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // One-hot key_held mask for a tracked code, zero otherwise.
  function automatic logic [7:0] key_mask(input logic [7:0] code);
    case (code)
      KEY_W:     return 8'(1) << KEY_W_BIT;
      KEY_A:     return 8'(1) << KEY_A_BIT;
      KEY_S:     return 8'(1) << KEY_S_BIT;
      KEY_D:     return 8'(1) << KEY_D_BIT;
      KEY_R:     return 8'(1) << KEY_R_BIT;
      KEY_G:     return 8'(1) << KEY_G_BIT;
      KEY_B:     return 8'(1) << KEY_B_BIT;
      KEY_SPACE: return 8'(1) << KEY_SPACE_BIT;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous event FIFO; the head output holds its last shown
// value while the FIFO is empty.
module ps2_evt_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_100,
  input  logic             vga_reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? last_q : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100 or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (!empty)  last_q <= mem[rd_ptr];
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_100) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code stream to {ext, brk, code} key events with a held-key bitmap.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of tracked keys.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_100,
  input  logic       vga_reset_n,
  input  logic [7:0] keycode_in,
  input  logic       keycode_valid,
  input  logic       ps2_error,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] key_held,
  output logic       overflow
);

  ps2_state_t state_q, state_d;
  ps2_evt_t   evt_d;
  ps2_evt_t   head;
  logic       emit;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] mask;
  logic       track_hit;
  logic [7:0] held_d;

  always_ff @(posedge clk_100 or negedge vga_reset_n) begin
    if (!vga_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    evt_d   = '{ext: 1'b0, brk: 1'b0, code: keycode_in};
    if (ps2_error) begin
      state_d = S_IDLE;
    end else if (keycode_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (keycode_in == PFX_E0)           state_d = S_E0;
          else if (keycode_in == PFX_F0)      state_d = S_F0;
          else if (!is_dropped_byte(keycode_in)) emit = 1'b1;
        end
        S_E0: begin
          if (keycode_in == PFX_F0)      state_d = S_E0F0;
          else if (keycode_in != PFX_E0) begin
            emit      = 1'b1;
            evt_d.ext = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_F0, S_E0F0: begin
          // A prefix after F0 is malformed: abandon the sequence silently.
          state_d = S_IDLE;
          if (keycode_in != PFX_E0 && keycode_in != PFX_F0) begin
            emit      = 1'b1;
            evt_d.ext = (state_q == S_E0F0);
            evt_d.brk = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign mask      = key_mask(keycode_in);
  assign track_hit = emit & ~evt_d.ext & (|mask);

  always_comb begin
    held_d = key_held;
    if (ps2_error)      held_d = '0;
    else if (track_hit) held_d = evt_d.brk ? (key_held & ~mask) : (key_held | mask);
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic is_repeat;
  assign is_repeat = track_hit & ~evt_d.brk & (|(key_held & mask));
  assign push      = emit & ~is_repeat;
`else
  assign push = emit;
`endif

  assign pop = evt_valid & evt_ready;

  always_ff @(posedge clk_100 or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      key_held <= '0;
      overflow <= 1'b0;
    end else begin
      key_held <= held_d;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100     (clk_100),
    .vga_reset_n (vga_reset_n),
    .push        (push),
    .pop         (pop),
    .wr_data     (evt_d),
    .rd_data     (head),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: a prefix-flag reference model
// predicts events, key_held and overflow; a negedge monitor checks them.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 4;
  localparam logic [7:0] KEYS [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h2D, 8'h34, 8'h32, 8'h29};
  localparam logic [7:0] DROPS [7] = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  logic       clk_100 = 1'b0;
  logic       vga_reset_n = 1'b0;
  logic [7:0] keycode_in = 8'h00;
  logic       keycode_valid = 1'b0;
  logic       ps2_error = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] key_held;
  logic       overflow;

  always #5 clk_100 = ~clk_100;

  ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_100       (clk_100),
    .vga_reset_n   (vga_reset_n),
    .keycode_in    (keycode_in),
    .keycode_valid (keycode_valid),
    .ps2_error     (ps2_error),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .key_held      (key_held),
    .overflow      (overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pending prefix flags, held bitmap, occupancy, expected events.
  bit         m_e0, m_f0;
  logic [7:0] m_held;
  bit         m_ovf;
  int         m_occ;
  logic [9:0] m_last;
  logic [9:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int key_bit(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (KEYS[i] == b) return i;
    return -1;
  endfunction

  function automatic bit is_drop(input logic [7:0] b);
    for (int i = 0; i < 7; i++) if (DROPS[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_e0 = 0; m_f0 = 0; m_held = '0; m_ovf = 0; m_occ = 0; m_last = '0;
    exp_q.delete();
  endtask

  // Called at posedge+1: drives one cycle of inputs, predicts the post-edge state.
  task automatic step(input bit v, input logic [7:0] b, input bit err, input bit rdy);
    bit emit = 0, ext = 0, brk = 0, enq, pop, push;
    logic [7:0] p_held;
    bit p_ovf;
    int p_occ, kb;
    keycode_valid = v; keycode_in = b; ps2_error = err; evt_ready = rdy;
    p_held = m_held;
    p_ovf  = m_ovf;
    if (err) begin
      m_e0 = 0; m_f0 = 0; p_held = '0;
    end else if (v) begin
      if (m_f0) begin
        if (b != 8'hE0 && b != 8'hF0) begin emit = 1; ext = m_e0; brk = 1; end
        m_e0 = 0; m_f0 = 0;
      end else if (b == 8'hE0) m_e0 = 1;
      else if (b == 8'hF0) m_f0 = 1;
      else if (m_e0) begin emit = 1; ext = 1; m_e0 = 0; end
      else if (!is_drop(b)) emit = 1;
    end
    enq = emit;
    kb  = key_bit(b);
    if (emit && !ext && kb >= 0) begin
`ifdef PS2_REPEAT_FILTER_EN
      if (!brk && m_held[kb]) enq = 0;
`endif
      p_held[kb] = !brk;
    end
    pop  = rdy && (m_occ > 0);
    push = enq && (m_occ < DEPTH || pop);
    if (enq && !push) p_ovf = 1;
    if (push) exp_q.push_back({ext, brk, b});
    p_occ = m_occ - int'(pop) + int'(push);
    @(posedge clk_100); #1;
    m_held = p_held; m_ovf = p_ovf; m_occ = p_occ;
    keycode_valid = 0; ps2_error = 0; evt_ready = 0;
  endtask

  task automatic do_reset();
    vga_reset_n = 1'b0;
    model_clear();
    repeat (2) begin @(posedge clk_100); #1; end
    vga_reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_occ > 0; i++) step(0, 8'h00, 0, 1);
    check("drain_empty", m_occ, 0);
  endtask

  always @(negedge clk_100) begin
    logic [9:0] e;
    check("evt_valid", evt_valid, m_occ != 0);
    check("key_held", key_held, m_held);
    check("overflow", overflow, m_ovf);
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("event", {evt_ext, evt_break, evt_code}, e);
        m_last = e;
      end
    end else if (!evt_valid) begin
      check("head_hold", {evt_ext, evt_break, evt_code}, m_last);
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    model_clear();
    repeat (2) begin @(posedge clk_100); #1; end
    check("reset_head", {evt_valid, evt_ext, evt_break, evt_code}, 0);
    vga_reset_n = 1'b1;

    // Single make, then pop.
    step(1, 8'h1D, 0, 0);
    check("make_1D_held", key_held, 8'h01);
    check("make_1D_valid", evt_valid, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Break, lone malformed F0 pair, extended make/break, dropped bytes.
    step(1, 8'hF0, 0, 1);
    step(1, 8'h1D, 0, 1);
    check("break_1D_held", key_held, 8'h00);
    step(1, 8'hF0, 0, 1);
    step(1, 8'hF0, 0, 1);
    step(1, 8'hE0, 0, 1);
    step(1, 8'h75, 0, 1);
    step(1, 8'hE0, 0, 1);
    step(1, 8'hF0, 0, 1);
    step(1, 8'h75, 0, 1);
    check("ext_held", key_held, 8'h00);
    step(1, 8'hAA, 0, 1);
    step(1, 8'hFA, 0, 1);
    drain();

    // Overflow: five makes with no consumer.
    step(1, 8'h1C, 0, 0);
    step(1, 8'h1B, 0, 0);
    step(1, 8'h23, 0, 0);
    step(1, 8'h2D, 0, 0);
    step(1, 8'h34, 0, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_held", key_held, 8'h3E);
    drain();

    // Error abandons a pending F0 and clears key_held.
    do_reset();
    step(1, 8'h1D, 0, 1);
    step(1, 8'hF0, 0, 1);
    step(0, 8'h00, 1, 1);
    check("err_clear_held", key_held, 8'h00);
    step(1, 8'h2D, 0, 1);
    check("err_make_held", key_held, 8'h10);
    step(0, 8'h00, 0, 1);

    // Reset discards a pending E0.
    step(1, 8'hE0, 0, 1);
    do_reset();
    step(1, 8'h75, 0, 1);
    step(0, 8'h00, 0, 1);

    // Typematic repeats.
    do_reset();
    step(1, 8'h1D, 0, 0);
    step(1, 8'h1D, 0, 0);
    step(1, 8'h1D, 0, 0);
`ifdef PS2_REPEAT_FILTER_EN
    check("repeat_count", m_occ, 1);
    check("repeat_dut_q", exp_q.size(), 1);
`else
    check("repeat_count", m_occ, 3);
    check("repeat_dut_q", exp_q.size(), 3);
`endif
    drain();

    // Randomized stream.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: b = KEYS[$urandom_range(0, 7)];
        4:          b = 8'hE0;
        5:          b = 8'hF0;
        6:          b = DROPS[$urandom_range(0, 6)];
        7:          b = ($urandom_range(0, 1) != 0) ? 8'h75 : 8'h6B;
        default:    b = 8'($urandom);
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, b, $urandom_range(0, 59) == 0, $urandom_range(0, 1) != 0);
    end
    drain();
    check("scoreboard_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
